// File: rtl/hazard_controller.sv
// hazard_controller: scoreboard interlock and flush sequencer for a 5-stage
// pipeline without forwarding. Tracks pending register-file writes, stalls
// decode on unreadable operands and squashes fetch/decode after redirects.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal operation, flush_FD follows ex_redirect only
// FLUSH | post-redirect squash window, fcnt counts remaining cycles

module hazard_controller #(
    parameter int ALU_LAT      = 3,
    parameter int LOAD_LAT     = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic        id_useRs,
    input  logic        id_useRt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_regWrite,
    input  logic [4:0]  id_dest,
    input  logic        id_isLoad,
    input  logic        ex_redirect,
    output logic        stall_FD,
    output logic        bubble_DE,
    output logic        flush_FD,
    output logic        issue,
    output logic [15:0] stallCount
);

    typedef enum logic {RUN, FLUSH} state_t;

    // A counter holds the number of cycles after the issue cycle during which
    // the register is still unreadable, so a consumer issues exactly LAT cycles
    // after its producer.
    localparam logic [CNT_W-1:0] ALU_SET   = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] LOAD_SET  = CNT_W'(LOAD_LAT - 1);
    localparam logic [2:0]       FLUSH_SET = 3'(FLUSH_CYCLES - 1);

    state_t           state;
    logic [2:0]       fcnt;
    logic [CNT_W-1:0] pend [32];

    logic haz_rs;
    logic haz_rt;
    logic hazard;
    logic flush_int;
    logic stall_int;
    logic issue_int;

    // Hazard detection and output decode; everything forced low during reset.
    always_comb begin
        haz_rs    = id_useRs && (id_rs != 5'd0) && (pend[id_rs] != '0);
        haz_rt    = id_useRt && (id_rt != 5'd0) && (pend[id_rt] != '0);
        hazard    = !reset && id_valid && (haz_rs || haz_rt);
        flush_int = !reset && ((state == FLUSH) || ex_redirect);
        stall_int = hazard && !flush_int;
        issue_int = !reset && id_valid && !stall_int && !flush_int;
    end

    assign flush_FD  = flush_int;
    assign stall_FD  = stall_int;
    assign bubble_DE = stall_int || flush_int;
    assign issue     = issue_int;

    // Scoreboard: countdown per register, reloaded by an issuing writer.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) pend[r] <= '0;
        end else begin
            pend[0] <= '0;
            for (int r = 1; r < 32; r++) begin
                if (issue_int && id_regWrite && (id_dest == 5'(r)))
                    pend[r] <= id_isLoad ? LOAD_SET : ALU_SET;
                else if (pend[r] != '0)
                    pend[r] <= pend[r] - 1'b1;
            end
        end
    end

    // Flush sequencer: a redirect (re)starts the squash window.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            fcnt  <= 3'd0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_redirect && (FLUSH_CYCLES > 1)) begin
                        state <= FLUSH;
                        fcnt  <= FLUSH_SET;
                    end
                end
                FLUSH: begin
                    if (ex_redirect) begin
                        fcnt <= FLUSH_SET;
                    end else if (fcnt == 3'd1) begin
                        state <= RUN;
                        fcnt  <= 3'd0;
                    end else begin
                        fcnt <= fcnt - 3'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    fcnt  <= 3'd0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clock) begin
        if (reset)
            stallCount <= 16'd0;
        else if (stall_int && (stallCount != 16'hFFFF))
            stallCount <= stallCount + 16'd1;
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed vector table, randomized run against
// a timestamp-based reference model, and a long-latency second instance that
// drives the stall counter into saturation.

module tb_hazard_controller;

    localparam int ALU_LAT      = 3;
    localparam int LOAD_LAT     = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int SAT_LAT      = 255;
    localparam int END_CYC      = 70000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, id_valid, id_useRs, id_useRt, id_regWrite, id_isLoad, ex_redirect;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        stall_FD, bubble_DE, flush_FD, issue;
    logic [15:0] stallCount;

    logic        sat_reset;
    logic        s_stall, s_bubble, s_flush, s_issue;
    logic [15:0] s_cnt;

    hazard_controller #(.ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT),
                        .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_useRs(id_useRs),
        .id_useRt(id_useRt), .id_rs(id_rs), .id_rt(id_rt), .id_regWrite(id_regWrite),
        .id_dest(id_dest), .id_isLoad(id_isLoad), .ex_redirect(ex_redirect),
        .stall_FD(stall_FD), .bubble_DE(bubble_DE), .flush_FD(flush_FD),
        .issue(issue), .stallCount(stallCount)
    );

    // Self-dependent writer of r1 with a 255-cycle latency: stalls 254 of
    // every 255 cycles, so the counter saturates well inside the run.
    hazard_controller #(.ALU_LAT(SAT_LAT), .LOAD_LAT(SAT_LAT),
                        .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(8)) dut_sat (
        .clock(clock), .reset(sat_reset), .id_valid(1'b1), .id_useRs(1'b1),
        .id_useRt(1'b0), .id_rs(5'd1), .id_rt(5'd0), .id_regWrite(1'b1),
        .id_dest(5'd1), .id_isLoad(1'b0), .ex_redirect(1'b0),
        .stall_FD(s_stall), .bubble_DE(s_bubble), .flush_FD(s_flush),
        .issue(s_issue), .stallCount(s_cnt)
    );

    typedef struct {
        logic       rst, v, urs, urt;
        logic [4:0] rs, rt;
        logic       rw;
        logic [4:0] dst;
        logic       ld, rd;
        logic       e_stall, e_bubble, e_flush, e_issue;
        logic [15:0] e_cnt;
    } vec_t;

    int checks = 0;
    int passed = 0;

    // Reference model: absolute cycle at which each register becomes readable,
    // last cycle of the current flush window, and a saturating stall tally.
    int cyc = 0;
    int ready [32];
    int flush_end = -1;
    int m_cnt = 0;
    int sat_start = 0;
    logic ms, mb, mf, mi;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic apply(input vec_t v);
        reset       = v.rst;
        id_valid    = v.v;
        id_useRs    = v.urs;
        id_useRt    = v.urt;
        id_rs       = v.rs;
        id_rt       = v.rt;
        id_regWrite = v.rw;
        id_dest     = v.dst;
        id_isLoad   = v.ld;
        ex_redirect = v.rd;
    endtask

    task automatic model_eval();
        logic hz;
        if (reset) begin
            ms = 0; mb = 0; mf = 0; mi = 0;
        end else begin
            mf = (cyc <= flush_end) || ex_redirect;
            hz = id_valid && ((id_useRs && id_rs != 0 && cyc < ready[id_rs]) ||
                              (id_useRt && id_rt != 0 && cyc < ready[id_rt]));
            ms = hz && !mf;
            mb = ms || mf;
            mi = id_valid && !ms && !mf;
        end
    endtask

    task automatic model_update();
        if (reset) begin
            for (int r = 0; r < 32; r++) ready[r] = 0;
            flush_end = -1;
            m_cnt = 0;
        end else begin
            if (mi && id_regWrite && id_dest != 0)
                ready[id_dest] = cyc + (id_isLoad ? LOAD_LAT : ALU_LAT);
            if (ex_redirect) flush_end = cyc + FLUSH_CYCLES - 1;
            if (ms && m_cnt < 65535) m_cnt++;
        end
        cyc++;
    endtask

    // One clock: drive, sample at negedge, compare, advance the model.
    task automatic run_cycle(input bit use_tbl, input vec_t v, input int idx);
        int n;
        apply(v);
        @(negedge clock);
        model_eval();
        if (use_tbl) begin
            check($sformatf("vec%0d stall_FD", idx),   {15'd0, stall_FD},  {15'd0, v.e_stall});
            check($sformatf("vec%0d bubble_DE", idx),  {15'd0, bubble_DE}, {15'd0, v.e_bubble});
            check($sformatf("vec%0d flush_FD", idx),   {15'd0, flush_FD},  {15'd0, v.e_flush});
            check($sformatf("vec%0d issue", idx),      {15'd0, issue},     {15'd0, v.e_issue});
            check($sformatf("vec%0d stallCount", idx), stallCount,         v.e_cnt);
        end else begin
            check("rnd stall_FD",   {15'd0, stall_FD},  {15'd0, ms});
            check("rnd bubble_DE",  {15'd0, bubble_DE}, {15'd0, mb});
            check("rnd flush_FD",   {15'd0, flush_FD},  {15'd0, mf});
            check("rnd issue",      {15'd0, issue},     {15'd0, mi});
            check("rnd stallCount", stallCount,         16'(m_cnt));
        end
        n = cyc - sat_start;
        if (!sat_reset && (n == 1000 || n == 40000))
            check($sformatf("sat count n=%0d", n), s_cnt, 16'(n - (n + SAT_LAT - 1) / SAT_LAT));
        @(posedge clock);
        model_update();
        #1;
    endtask

    vec_t tbl [29];
    vec_t rv;

    initial begin
        for (int r = 0; r < 32; r++) ready[r] = 0;
        //            rst v urs urt rs    rt    rw dst    ld rd  st bu fl is cnt
        tbl[0]  = '{1, 0, 0, 0, 5'd0,  5'd0, 0, 5'd0,  0, 0,  0, 0, 0, 0, 16'd0};
        tbl[1]  = '{1, 1, 1, 0, 5'd5,  5'd0, 0, 5'd0,  0, 1,  0, 0, 0, 0, 16'd0};
        tbl[2]  = '{0, 0, 0, 0, 5'd0,  5'd0, 0, 5'd0,  0, 0,  0, 0, 0, 0, 16'd0};
        tbl[3]  = '{0, 1, 0, 0, 5'd0,  5'd0, 1, 5'd0,  1, 0,  0, 0, 0, 1, 16'd0};
        tbl[4]  = '{0, 1, 1, 1, 5'd0,  5'd0, 0, 5'd0,  0, 0,  0, 0, 0, 1, 16'd0};
        tbl[5]  = '{0, 1, 0, 0, 5'd0,  5'd0, 1, 5'd5,  0, 0,  0, 0, 0, 1, 16'd0};
        tbl[6]  = '{0, 1, 1, 0, 5'd5,  5'd0, 0, 5'd0,  0, 0,  1, 1, 0, 0, 16'd0};
        tbl[7]  = '{0, 1, 1, 0, 5'd5,  5'd0, 0, 5'd0,  0, 0,  1, 1, 0, 0, 16'd1};
        tbl[8]  = '{0, 1, 1, 0, 5'd5,  5'd0, 0, 5'd0,  0, 0,  0, 0, 0, 1, 16'd2};
        tbl[9]  = '{0, 0, 0, 0, 5'd0,  5'd0, 0, 5'd0,  0, 0,  0, 0, 0, 0, 16'd2};
        tbl[10] = '{0, 1, 0, 0, 5'd0,  5'd0, 1, 5'd7,  1, 0,  0, 0, 0, 1, 16'd2};
        tbl[11] = '{0, 1, 0, 1, 5'd0,  5'd7, 0, 5'd0,  0, 0,  1, 1, 0, 0, 16'd2};
        tbl[12] = '{0, 1, 0, 1, 5'd0,  5'd7, 0, 5'd0,  0, 0,  1, 1, 0, 0, 16'd3};
        tbl[13] = '{0, 1, 0, 1, 5'd0,  5'd7, 0, 5'd0,  0, 0,  1, 1, 0, 0, 16'd4};
        tbl[14] = '{0, 1, 0, 1, 5'd0,  5'd7, 0, 5'd0,  0, 0,  0, 0, 0, 1, 16'd5};
        tbl[15] = '{0, 1, 0, 0, 5'd0,  5'd0, 1, 5'd7,  1, 0,  0, 0, 0, 1, 16'd5};
        tbl[16] = '{0, 1, 0, 0, 5'd7,  5'd0, 0, 5'd0,  0, 0,  0, 0, 0, 1, 16'd5};
        tbl[17] = '{0, 0, 0, 0, 5'd0,  5'd0, 0, 5'd0,  0, 0,  0, 0, 0, 0, 16'd5};
        tbl[18] = '{0, 1, 0, 0, 5'd0,  5'd0, 1, 5'd9,  0, 0,  0, 0, 0, 1, 16'd5};
        tbl[19] = '{0, 1, 1, 0, 5'd9,  5'd0, 1, 5'd12, 0, 1,  0, 1, 1, 0, 16'd5};
        tbl[20] = '{0, 1, 1, 0, 5'd9,  5'd0, 1, 5'd12, 0, 1,  0, 1, 1, 0, 16'd5};
        tbl[21] = '{0, 1, 1, 0, 5'd9,  5'd0, 1, 5'd12, 0, 0,  0, 1, 1, 0, 16'd5};
        tbl[22] = '{0, 1, 1, 0, 5'd12, 5'd0, 0, 5'd0,  0, 0,  0, 0, 0, 1, 16'd5};
        tbl[23] = '{0, 1, 0, 0, 5'd0,  5'd0, 1, 5'd3,  1, 0,  0, 0, 0, 1, 16'd5};
        tbl[24] = '{0, 1, 0, 0, 5'd0,  5'd0, 1, 5'd3,  0, 0,  0, 0, 0, 1, 16'd5};
        tbl[25] = '{0, 1, 1, 0, 5'd3,  5'd0, 0, 5'd0,  0, 0,  1, 1, 0, 0, 16'd5};
        tbl[26] = '{0, 1, 1, 0, 5'd3,  5'd0, 0, 5'd0,  0, 0,  1, 1, 0, 0, 16'd6};
        tbl[27] = '{0, 1, 1, 0, 5'd3,  5'd0, 0, 5'd0,  0, 0,  0, 0, 0, 1, 16'd7};
        tbl[28] = '{0, 0, 0, 0, 5'd0,  5'd0, 0, 5'd0,  0, 0,  0, 0, 0, 0, 16'd7};

        sat_reset = 1'b1;
        apply(tbl[0]);
        @(posedge clock);
        #1;
        sat_reset = 1'b0;
        sat_start = cyc;

        for (int i = 0; i < 29; i++) run_cycle(1'b1, tbl[i], i);

        while (cyc < END_CYC) begin
            rv.rst = ($urandom_range(0, 299) == 0);
            rv.v   = ($urandom_range(0, 3) != 0);
            rv.urs = 1'($urandom_range(0, 1));
            rv.urt = 1'($urandom_range(0, 1));
            rv.rs  = 5'($urandom_range(0, 3));
            rv.rt  = 5'($urandom_range(0, 3));
            rv.rw  = 1'($urandom_range(0, 1));
            rv.dst = 5'($urandom_range(0, 3));
            rv.ld  = 1'($urandom_range(0, 1));
            rv.rd  = ($urandom_range(0, 7) == 0);
            rv.e_stall = 0; rv.e_bubble = 0; rv.e_flush = 0; rv.e_issue = 0; rv.e_cnt = 0;
            run_cycle(1'b0, rv, 0);
        end

        // Saturated instance: move to a stall cycle, then reset it mid-stall.
        while (((cyc - sat_start) % SAT_LAT) == 0) begin
            @(posedge clock);
            cyc++;
            #1;
        end
        @(negedge clock);
        check("sat stall_FD mid-stall", {15'd0, s_stall}, 16'd1);
        check("sat stallCount saturated", s_cnt, 16'hFFFF);
        @(posedge clock);
        #1;
        sat_reset = 1'b1;
        @(negedge clock);
        check("sat stall_FD in reset", {15'd0, s_stall}, 16'd0);
        check("sat bubble_DE in reset", {15'd0, s_bubble}, 16'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("sat stallCount after reset", s_cnt, 16'd0);
        check("sat stall_FD after reset", {15'd0, s_stall}, 16'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
